imm_extend_pipe: RTL and testbench

Parametrised, pipelined immediate-extension unit for the decode/execute boundary of the pipelined MIPS core. It takes an IN_W-bit immediate plus a 2-bit mode and produces an OUT_W-bit operand. Supported modes are sign-extend, zero-extend, upper-load (LUI) placement, and branch-offset (sign-extend then shift left 2). The result passes through STAGES register stages with a valid/ready handshake, a global stall, and a synchronous flush. A TAG_W sideband tag travels alongside each result.

---
 rtl/imm_extend_pipe.sv | 84 ++++++++
 tb/tb_imm_extend_pipe.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension unit for the MIPS decode/execute boundary.
// Rigid STAGES-deep pipeline carrying the extended operand and a sideband tag.
module imm_extend_pipe #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_imm,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_data;
    logic             advance;

    logic [STAGES-1:0] valid_q;
    logic [OUT_W-1:0]  data_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];

    assign sext = {{PAD_W{in_imm[IN_W-1]}}, in_imm};

    // NOTE: full case plus a default assignment first keeps this block latch-free.
    always_comb begin
        ext_data = sext;
        case (in_mode)
            MODE_SIGN:   ext_data = sext;
            MODE_ZERO:   ext_data = {{PAD_W{1'b0}}, in_imm};
            MODE_UPPER:  ext_data = {in_imm, {PAD_W{1'b0}}};
            MODE_BRANCH: ext_data = {sext[OUT_W-3:0], 2'b00};
            default:     ext_data = sext;
        endcase
    end

    // The whole pipe moves only when the last slot is empty or being drained.
    assign advance  = !valid_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    // NOTE: state uses non-blocking assignments so every stage samples the
    // pre-edge value of its predecessor; data/tag arrays are reset explicitly
    // because the outputs must read zero after reset, not just be invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q[0] <= in_valid;
            data_q[0]  <= ext_data;
            tag_q[0]   <= in_tag;
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                data_q[k]  <= data_q[k-1];
                tag_q[k]   <= tag_q[k-1];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed mode/latency/stall/reset
// vectors, then randomized traffic against a queue-based pipeline model.
module tb_imm_extend_pipe;

    localparam int IN_W   = 16;
    localparam int OUT_W  = 32;
    localparam int STAGES = 3;
    localparam int TAG_W  = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [IN_W-1:0]    in_imm = '0;
    logic [1:0]         in_mode = '0;
    logic [TAG_W-1:0]   in_tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [OUT_W-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;

    int n_checks = 0;
    int n_pass   = 0;

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Extension computed arithmetically from the mode rules.
    function automatic logic [OUT_W-1:0] ref_ext(input longint imm, input int mode);
        longint s;
        longint r;
        s = (imm >= (longint'(1) << (IN_W-1))) ? imm - (longint'(1) << IN_W) : imm;
        case (mode)
            0:       r = s;
            1:       r = imm;
            2:       r = imm * (longint'(1) << (OUT_W-IN_W));
            default: r = s * 4;
        endcase
        return r[OUT_W-1:0];
    endfunction

    typedef struct {
        bit               v;
        logic [OUT_W-1:0] d;
        logic [TAG_W-1:0] t;
    } ent_t;

    ent_t pipe[$];

    task automatic model_reset();
        ent_t e;
        e.v = 1'b0; e.d = '0; e.t = '0;
        pipe.delete();
        for (int k = 0; k < STAGES; k++) pipe.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_directed(input logic [15:0] imm, input logic [1:0] mode,
                                 input logic [4:0] tag, input logic [31:0] exp, input string name);
        @(negedge clk);
        in_valid = 1'b1; in_imm = imm; in_mode = mode; in_tag = tag; out_ready = 1'b1;
        check({name, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (STAGES-1) @(posedge clk);
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_data"}, out_data, exp);
        check({name, "_tag"}, out_tag, tag);
    endtask

    initial begin
        int lat;
        ent_t last;
        ent_t e;
        bit   adv;

        // Reset state
        do_reset();
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, '0);
        check("rst_tag", out_tag, '0);
        check("rst_in_ready", in_ready, 1'b1);

        // Mode table
        send_directed(16'h8004, 2'b00, 5'd1, 32'hFFFF8004, "m00_8004");
        send_directed(16'h8004, 2'b01, 5'd2, 32'h00008004, "m01_8004");
        send_directed(16'h8004, 2'b10, 5'd3, 32'h80040000, "m10_8004");
        send_directed(16'h8004, 2'b11, 5'd4, 32'hFFFE0010, "m11_8004");
        send_directed(16'h7FFF, 2'b00, 5'd5, 32'h00007FFF, "m00_7fff");
        send_directed(16'h7FFF, 2'b11, 5'd6, 32'h0001FFFC, "m11_7fff");

        // Latency: first out_valid exactly STAGES cycles after acceptance, then tags in order
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_imm = 16'(i); in_mode = 2'b01; in_tag = 5'(i);
            @(posedge clk);
            if (i == 1) lat = 0;
            @(negedge clk);
            if (lat == 0 && (out_valid || i == 8)) lat = i;
            if (out_valid) begin
                check("stream_tag", out_tag, 5'(i - STAGES + 1));
                check("stream_data", out_data, 32'(i - STAGES + 1));
            end
        end
        in_valid = 1'b0;
        check("latency", lat, STAGES);

        // Stall then reset with the pipe full
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; in_imm = 16'(i + 16); in_mode = 2'b01; in_tag = 5'(i);
            @(negedge clk);
        end
        check("stall_valid", out_valid, 1'b1);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_tag", out_tag, 5'd1);
        check("stall_data", out_data, 32'd17);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_data", out_data, '0);
        check("midrst_tag", out_tag, '0);
        check("midrst_in_ready", in_ready, 1'b1);

        // Randomized traffic against the queue model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            last = pipe[STAGES-1];
            check("rnd_valid", out_valid, last.v);
            if (last.v) begin
                check("rnd_data", out_data, last.d);
                check("rnd_tag", out_tag, last.t);
            end
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_imm    = IN_W'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = TAG_W'($urandom);
            #1;
            adv = !last.v || out_ready;
            check("rnd_in_ready", in_ready, adv);
            if (rst) begin
                model_reset();
            end else if (flush) begin
                for (int k = 0; k < STAGES; k++) pipe[k].v = 1'b0;
            end else if (adv) begin
                e.v = in_valid;
                e.d = ref_ext(longint'(in_imm), int'(in_mode));
                e.t = in_tag;
                void'(pipe.pop_back());
                pipe.push_front(e);
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
